// File: rtl/intr_sequencer_if.sv
// Signal bundle between the interrupt sequencer and the port block, control unit and data memory.
interface intr_sequencer_if;
  logic       intr_flag;
  logic       intr_clear;
  logic       inst_boundary;
  logic [7:0] pc_in;
  logic [3:0] flags_in;
  logic [7:0] sp_in;
  logic       rti;
  logic       stall;
  logic       flush;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       sp_dec;
  logic       pc_load;
  logic [7:0] pc_next;
  logic       in_service;

  modport master (
    input  intr_flag, inst_boundary, pc_in, flags_in, sp_in, rti, mem_rdata, mem_ack,
    output intr_clear, stall, flush, mem_req, mem_we, mem_addr, mem_wdata,
           sp_dec, pc_load, pc_next, in_service
  );

  modport slave (
    output intr_flag, inst_boundary, pc_in, flags_in, sp_in, rti, mem_rdata, mem_ack,
    input  intr_clear, stall, flush, mem_req, mem_we, mem_addr, mem_wdata,
           sp_dec, pc_load, pc_next, in_service
  );
endinterface

// File: rtl/intr_sequencer.sv
// Interrupt entry sequencer: ack, pipeline drain, stack push of the return PC, vector fetch, jump.
// Defining INTR_SAVE_FLAGS_EN adds a second push of the CCR flags after the PC.
module intr_sequencer #(
  parameter logic [7:0] VECTOR_ADDR  = 8'h01,
  parameter int         DRAIN_CYCLES = 3
) (
  input logic              clk,
  input logic              rst_n,
  intr_sequencer_if.master io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_DRAIN, S_PUSH_PC, S_PUSH_FLG, S_FETCH_VEC, S_JUMP
  } state_t;

  state_t     r_state;
  logic [3:0] r_drain_cnt;
  logic [7:0] r_saved_pc;
  logic       r_intr_clear;
  logic       r_stall;
  logic       r_flush;
  logic       r_mem_req;
  logic       r_mem_we;
  logic [7:0] r_mem_addr;
  logic [7:0] r_mem_wdata;
  logic       r_sp_dec;
  logic       r_pc_load;
  logic [7:0] r_pc_next;
  logic       r_in_service;
  logic       w_accept;

`ifdef INTR_SAVE_FLAGS_EN
  logic [3:0] r_saved_flags;
`else
  logic       w_unused_flags;
  assign w_unused_flags = ^io_bus.flags_in;
`endif

  assign w_accept = io_bus.intr_flag && !r_in_service && io_bus.inst_boundary;

  // Each push state opens with a gap cycle (mem_req low), then requests until acked.
  // The stack address subtracts a decrement the CPU has not yet applied to sp_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_drain_cnt  <= '0;
      r_saved_pc   <= '0;
      r_intr_clear <= 1'b0;
      r_stall      <= 1'b0;
      r_flush      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_sp_dec     <= 1'b0;
      r_pc_load    <= 1'b0;
      r_pc_next    <= '0;
      r_in_service <= 1'b0;
`ifdef INTR_SAVE_FLAGS_EN
      r_saved_flags <= '0;
`endif
    end else begin
      r_intr_clear <= 1'b0;
      r_flush      <= 1'b0;
      r_sp_dec     <= 1'b0;
      r_pc_load    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stall <= 1'b0;
          if (io_bus.rti && r_in_service) begin
            r_in_service <= 1'b0;
          end else if (w_accept) begin
            r_saved_pc   <= io_bus.pc_in;
`ifdef INTR_SAVE_FLAGS_EN
            r_saved_flags <= io_bus.flags_in;
`endif
            r_intr_clear <= 1'b1;
            r_flush      <= 1'b1;
            r_stall      <= 1'b1;
            r_state      <= S_ACK;
          end
        end
        S_ACK: begin
          r_drain_cnt <= 4'(DRAIN_CYCLES);
          r_state     <= S_DRAIN;
        end
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt - 4'd1;
          if (r_drain_cnt == 4'd1) begin
            r_mem_we    <= 1'b1;
            r_mem_wdata <= r_saved_pc;
            r_mem_addr  <= io_bus.sp_in;
            r_state     <= S_PUSH_PC;
          end
        end
        S_PUSH_PC, S_PUSH_FLG: begin
          r_mem_addr <= io_bus.sp_in - {7'b0, r_sp_dec};
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (io_bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_sp_dec  <= 1'b1;
`ifdef INTR_SAVE_FLAGS_EN
            if (r_state == S_PUSH_PC) begin
              r_mem_wdata <= {4'b0000, r_saved_flags};
              r_state     <= S_PUSH_FLG;
            end else
`endif
            begin
              r_mem_we    <= 1'b0;
              r_mem_wdata <= '0;
              r_mem_addr  <= VECTOR_ADDR;
              r_state     <= S_FETCH_VEC;
            end
          end
        end
        S_FETCH_VEC: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (io_bus.mem_ack) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_pc_next  <= io_bus.mem_rdata;
            r_pc_load  <= 1'b1;
            r_state    <= S_JUMP;
          end
        end
        S_JUMP: begin
          r_in_service <= 1'b1;
          r_stall      <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.intr_clear = r_intr_clear;
  assign io_bus.stall      = r_stall;
  assign io_bus.flush      = r_flush;
  assign io_bus.mem_req    = r_mem_req;
  assign io_bus.mem_we     = r_mem_we;
  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.mem_wdata  = r_mem_wdata;
  assign io_bus.sp_dec     = r_sp_dec;
  assign io_bus.pc_load    = r_pc_load;
  assign io_bus.pc_next    = r_pc_next;
  assign io_bus.in_service = r_in_service;

endmodule

// File: tb/tb_intr_sequencer.sv
// Self-checking bench for intr_sequencer: vector table of interrupt entries plus hand-written
// corner sequences, with a memory/stack model feeding a transaction scoreboard.
module tb_intr_sequencer;

  localparam int DRAIN = 3;
`ifdef INTR_SAVE_FLAGS_EN
  localparam int FLG = 1;
`else
  localparam int FLG = 0;
`endif

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct packed {
    logic ack;
    txn_t t;
  } obs_t;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] flags;
    logic [7:0] sp;
    logic [7:0] vec;
    int         pushDly;
    int         fetchDly;
    int         expLat;
    int         expSpDec;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  intr_sequencer_if bus ();

  intr_sequencer #(.VECTOR_ADDR(8'h01), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] spBase;
  int         spDecApplied = 0;
  logic       prevSpDec = 1'b0;
  int         pushDelay = 0;
  int         fetchDelay = 0;
  int         waitCnt = 0;
  int         cycleCnt = 0;
  int         clearCnt = 0, flushCnt = 0, spDecCnt = 0, loadCnt = 0;
  int         clearCycle = 0, loadCycle = 0;
  int         clearBase = 0, flushBase = 0, spDecBase = 0, loadBase = 0;
  int         nCompared = 0;
  int         nMismatched = 0;
  obs_t       mon;

  txn_t       expTxn[$];
  logic [7:0] expJump[$];
  obs_t       obsTxn[$];
  logic [7:0] obsJump[$];

  vec_t       vectors[4];

  // The CPU applies an sp_dec one cycle after it is seen.
  assign bus.sp_in = spBase - 8'(spDecApplied);

  // Memory responder and event monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      waitCnt       = 0;
      prevSpDec     = 1'b0;
    end else begin
      cycleCnt++;
      if (prevSpDec) spDecApplied++;
      prevSpDec = bus.sp_dec;
      if (bus.sp_dec) spDecCnt++;
      if (bus.intr_clear) begin
        clearCnt++;
        clearCycle = cycleCnt;
      end
      if (bus.flush) flushCnt++;
      if (bus.pc_load) begin
        loadCnt++;
        loadCycle = cycleCnt;
        obsJump.push_back(bus.pc_next);
      end
      if (bus.mem_req) begin
        mon.ack = (waitCnt >= (bus.mem_we ? pushDelay : fetchDelay));
        mon.t   = {bus.mem_we, bus.mem_addr, (bus.mem_we ? bus.mem_wdata : 8'h00)};
        obsTxn.push_back(mon);
        bus.mem_ack   = mon.ack;
        bus.mem_rdata = mon.ack ? mem[bus.mem_addr] : 8'h00;
        waitCnt       = mon.ack ? 0 : waitCnt + 1;
      end else begin
        bus.mem_ack = 1'b0;
        waitCnt     = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic armEntry(input vec_t v);
    txn_t t;
    mem[8'h01]    = v.vec;
    bus.pc_in     = v.pc;
    bus.flags_in  = v.flags;
    spBase        = v.sp + 8'(spDecApplied);
    pushDelay     = v.pushDly;
    fetchDelay    = v.fetchDly;
    t = {1'b1, v.sp, v.pc};
    expTxn.push_back(t);
    if (FLG != 0) begin
      t = {1'b1, v.sp - 8'd1, {4'h0, v.flags}};
      expTxn.push_back(t);
    end
    t = {1'b0, 8'h01, 8'h00};
    expTxn.push_back(t);
    expJump.push_back(v.vec);
    clearBase = clearCnt;
    flushBase = flushCnt;
    spDecBase = spDecCnt;
    loadBase  = loadCnt;
  endtask

  task automatic waitLoad();
    int n;
    n = 0;
    while (loadCnt == loadBase && n < 200) begin
      tick();
      if (clearCnt != clearBase) bus.intr_flag = 1'b0;
      n++;
    end
    checkOutput("pc_load_seen", 32'(loadCnt - loadBase), 32'd1);
  endtask

  task automatic scoreEntry(input vec_t v);
    obs_t       ob;
    logic [7:0] j;
    checkOutput("latency", 32'(loadCycle - clearCycle + 1), 32'(v.expLat));
    checkOutput("intr_clear_pulses", 32'(clearCnt - clearBase), 32'd1);
    checkOutput("flush_pulses", 32'(flushCnt - flushBase), 32'd1);
    checkOutput("sp_dec_pulses", 32'(spDecCnt - spDecBase), 32'(v.expSpDec));
    while (obsTxn.size() != 0) begin
      ob = obsTxn.pop_front();
      if (expTxn.size() == 0) begin
        checkOutput("mem_txn_extra", 32'(ob.t), 32'd0);
      end else begin
        checkOutput("mem_txn", 32'(ob.t), 32'(expTxn[0]));
        if (ob.ack) void'(expTxn.pop_front());
      end
    end
    checkOutput("mem_txn_left", 32'(expTxn.size()), 32'd0);
    while (obsJump.size() != 0) begin
      j = obsJump.pop_front();
      if (expJump.size() == 0) checkOutput("pc_next_extra", 32'(j), 32'hFFFF_FFFF);
      else checkOutput("pc_next", 32'(j), 32'(expJump.pop_front()));
    end
    checkOutput("jump_left", 32'(expJump.size()), 32'd0);
  endtask

  task automatic endService();
    bus.rti = 1'b1;
    tick();
    bus.rti = 1'b0;
    checkOutput("in_service_after_rti", 32'(bus.in_service), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    armEntry(v);
    bus.inst_boundary = 1'b1;
    bus.intr_flag     = 1'b1;
    waitLoad();
    scoreEntry(v);
    tick();
    checkOutput("in_service_after_jump", 32'(bus.in_service), 32'd1);
    checkOutput("stall_after_jump", 32'(bus.stall), 32'd0);
    endService();
  endtask

  function automatic logic [31:0] allOutputs();
    return {bus.intr_clear, bus.stall, bus.flush, bus.mem_req, bus.mem_we, bus.sp_dec,
            bus.pc_load, bus.in_service, bus.mem_addr, bus.mem_wdata, bus.pc_next};
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors[0] = '{8'h42, 4'hA, 8'hFF, 8'hA0, 0, 0, 9 + 2 * FLG, 1 + FLG};
    vectors[1] = '{8'h10, 4'h5, 8'h80, 8'h33, 4, 0, 13 + 6 * FLG, 1 + FLG};
    vectors[2] = '{8'hFE, 4'hF, 8'h10, 8'h7F, 1, 2, 12 + 3 * FLG, 1 + FLG};
    vectors[3] = '{8'h00, 4'h0, 8'h01, 8'hFF, 0, 0, 9 + 2 * FLG, 1 + FLG};

    rst_n             = 1'b0;
    bus.intr_flag     = 1'b0;
    bus.inst_boundary = 1'b0;
    bus.pc_in         = 8'h00;
    bus.flags_in      = 4'h0;
    bus.rti           = 1'b0;
    spBase            = 8'hFF;
    #2;
    checkOutput("reset_outputs", allOutputs(), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    checkOutput("idle_stall", 32'(bus.stall), 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(vectors[i]);

    // Boundary gating: no acceptance until inst_boundary rises.
    armEntry(vectors[0]);
    bus.inst_boundary = 1'b0;
    bus.intr_flag     = 1'b1;
    repeat (5) tick();
    checkOutput("gated_no_clear", 32'(clearCnt - clearBase), 32'd0);
    bus.inst_boundary = 1'b1;
    tick();
    checkOutput("gated_accept", 32'(clearCnt - clearBase), 32'd1);
    waitLoad();
    scoreEntry(vectors[0]);
    tick();
    endService();

    // Nesting mask: a new interrupt waits for rti, then is accepted the next cycle.
    armEntry(vectors[2]);
    bus.intr_flag = 1'b1;
    waitLoad();
    scoreEntry(vectors[2]);
    tick();
    armEntry(vectors[1]);
    bus.intr_flag = 1'b1;
    repeat (4) tick();
    checkOutput("masked_while_in_service", 32'(clearCnt - clearBase), 32'd0);
    bus.rti = 1'b1;
    tick();
    bus.rti = 1'b0;
    checkOutput("rti_clears_in_service", 32'(bus.in_service), 32'd0);
    checkOutput("no_accept_on_rti_cycle", 32'(clearCnt - clearBase), 32'd0);
    tick();
    checkOutput("accept_after_rti", 32'(clearCnt - clearBase), 32'd1);
    waitLoad();
    scoreEntry(vectors[1]);
    tick();
    endService();

    // Reset during DRAIN abandons the sequence; a re-raised flag is taken afterwards.
    armEntry(vectors[0]);
    bus.intr_flag = 1'b1;
    tick();
    checkOutput("reset_seq_ack", 32'(clearCnt - clearBase), 32'd1);
    bus.intr_flag = 1'b0;
    tick();
    tick();
    checkOutput("stall_in_drain", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", allOutputs(), 32'd0);
    expTxn.delete();
    expJump.delete();
    obsTxn.delete();
    obsJump.delete();
    repeat (3) tick();
    checkOutput("no_pc_load_after_reset", 32'(loadCnt - loadBase), 32'd0);
    armEntry(vectors[0]);
    bus.intr_flag = 1'b1;
    rst_n = 1'b1;
    waitLoad();
    scoreEntry(vectors[0]);
    tick();
    checkOutput("in_service_after_reset_entry", 32'(bus.in_service), 32'd1);
    endService();

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
